gpio_pin_agent: RTL and testbench

- External-side partner of the parity-protected GPIO port.
- Receives the 17-bit word the GPIO block drives (16 data bits plus a parity bit in bit 16), debounces it, checks parity and queues it for a local consumer.
- Transmits local 16-bit words toward the GPIO block's input pins with parity generated per the shared parity select.
- Used as the pin-level endpoint in system and unit benches, and as the off-chip model of the peripheral.

---
 rtl/gpio_pin_agent.sv | 180 ++++++++++++++++++
 tb/tb_gpio_pin_agent.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pin_agent.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_pin_agent: pin-level partner of the parity-protected GPIO port.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gpio_pin_agent #(
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] gpio_out,
  output logic [16:0] gpio_in,
  input  logic        parity_sel,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_inject_err,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] rx_data,
  output logic        rx_perr,
  output logic        rx_overflow,
  output logic [7:0]  perr_count,
  input  logic        clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] c_cnt_max  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] c_hold_max = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   c_depth    = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} tx_state_e;

  function automatic logic par_bit(input logic [15:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  tx_state_e      tx_state_q, tx_state_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [16:0]    gpio_in_q, gpio_in_d;
  logic           tx_ready_q, tx_ready_d;

  logic [16:0]    s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [16:0]    last_q, last_d;
  logic [16:0]    mem_q [DEPTH];
  logic [16:0]    mem_d [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     perr_cnt_q, perr_cnt_d;

  logic           push, perr, pop, store, full;
  logic [16:0]    head;

  always_comb begin
    tx_state_d = tx_state_q;
    hold_cnt_d = hold_cnt_q;
    gpio_in_d  = gpio_in_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      IDLE: begin
        if (tx_valid) begin
          gpio_in_d  = {par_bit(tx_data, parity_sel) ^ tx_inject_err, tx_data};
          tx_state_d = HOLD;
          hold_cnt_d = c_hold_max;
          tx_ready_d = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          tx_state_d = IDLE;
          tx_ready_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  // A word becomes a push candidate once its sample has been seen STABLE_CYCLES times.
  always_comb begin
    s_d    = gpio_out;
    if (gpio_out != s_q)
      cnt_d = '0;
    else if (cnt_q == c_cnt_max)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
    push   = (cnt_q == c_cnt_max) && (s_q != last_q);
    perr   = s_q[16] != par_bit(s_q[15:0], parity_sel);
    last_d = push ? s_q : last_q;
  end

  always_comb begin
    full    = (count_q == c_depth);
    pop     = rx_valid && rx_ready;
    store   = push && (!full || pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (store) begin
      mem_d[wr_q] = {perr, s_q[15:0]};
      wr_d        = wr_q + 1'b1;
    end
    if (pop)
      rd_d = rd_q + 1'b1;
    case ({store, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (clr)
      ovf_d = 1'b0;
    else if (push && full && !pop)
      ovf_d = 1'b1;
    else
      ovf_d = ovf_q;

    if (clr)
      perr_cnt_d = '0;
    else if (push && perr && (perr_cnt_q != 8'hFF))
      perr_cnt_d = perr_cnt_q + 1'b1;
    else
      perr_cnt_d = perr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= IDLE;
      hold_cnt_q <= '0;
      gpio_in_q  <= '0;
      tx_ready_q <= 1'b1;
      s_q        <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      perr_cnt_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      hold_cnt_q <= hold_cnt_d;
      gpio_in_q  <= gpio_in_d;
      tx_ready_q <= tx_ready_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign head        = mem_q[rd_q];
  assign gpio_in     = gpio_in_q;
  assign tx_ready    = tx_ready_q;
  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? head[15:0] : 16'h0000;
  assign rx_perr     = rx_valid ? head[16] : 1'b0;
  assign rx_overflow = ovf_q;
  assign perr_count  = perr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pin_agent.sv
`default_nettype none
// Bench for gpio_pin_agent: queued expectations for TX words and RX pops,
// directed stimulus for parity, debounce, overflow, clear and reset.
module tb_gpio_pin_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] gpio_out;
  logic [16:0] gpio_in;
  logic        parity_sel;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_inject_err;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_perr;
  logic        rx_overflow;
  logic [7:0]  perr_count;
  logic        clr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  logic [16:0] txq[$];
  logic [16:0] rxq[$];

  gpio_pin_agent #(.DEPTH(4), .STABLE_CYCLES(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .parity_sel(parity_sel), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_inject_err(tx_inject_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_overflow(rx_overflow), .perr_count(perr_count), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // TX monitor: a falling tx_ready marks a handshake; the word and hold length are checked.
  logic [16:0] tx_cur;
  int          tx_low;
  bit          tx_in_hold = 0;
  always @(negedge clk) begin
    if (reset) begin
      tx_in_hold = 0;
    end else if (!tx_ready) begin
      if (!tx_in_hold) begin
        tx_in_hold = 1;
        tx_low     = 1;
        if (txq.size() == 0) begin
          check("tx_unexpected_handshake", 32'(gpio_in), 32'h1FFFF);
          tx_cur = gpio_in;
        end else begin
          tx_cur = txq.pop_front();
          check("tx_word", 32'(gpio_in), 32'(tx_cur));
        end
      end else begin
        tx_low++;
        check("tx_hold_word", 32'(gpio_in), 32'(tx_cur));
      end
    end else if (tx_in_hold) begin
      tx_in_hold = 0;
      check("tx_ready_low_cycles", 32'(tx_low), 32'd4);
      check("tx_idle_keeps_word", 32'(gpio_in), 32'(tx_cur));
    end
  end

  // RX monitor: every pop is matched against the next queued expectation.
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      n_pops++;
      if (rxq.size() == 0)
        check("rx_unexpected_pop", 32'({rx_perr, rx_data}), 32'hDEAD_BEEF);
      else
        check("rx_word", 32'({rx_perr, rx_data}), 32'(rxq.pop_front()));
    end
  end

  task automatic send(input logic [15:0] d, input logic sel, input logic inj,
                      input logic [16:0] exp);
    int n = 0;
    while (!tx_ready && n < 50) begin
      tick();
      n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    parity_sel    = sel;
    tx_data       = d;
    tx_inject_err = inj;
    tx_valid      = 1'b1;
    txq.push_back(exp);
    tick();
    tx_valid      = 1'b0;
    tx_inject_err = 1'b0;
    parity_sel    = ~sel;
  endtask

  task automatic hold_rx(input logic [16:0] w, input int cycles);
    gpio_out = w;
    repeat (cycles) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [16:0] ovf_words [5];
  int pops_before;

  initial begin
    reset = 1'b1; gpio_out = '0; parity_sel = 1'b0; tx_valid = 1'b0;
    tx_data = '0; tx_inject_err = 1'b0; rx_ready = 1'b1; clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_gpio_in", 32'(gpio_in), 32'h0);
    check("reset_tx_ready", 32'(tx_ready), 32'h1);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_perr", 32'(rx_perr), 32'h0);
    check("reset_rx_overflow", 32'(rx_overflow), 32'h0);
    check("reset_perr_count", 32'(perr_count), 32'h0);
    tick();

    // One-cycle glitch, then back to 0 which equals the post-reset last value.
    hold_rx(17'h0_00FF, 1);
    hold_rx(17'h0_0000, 6);
    check("glitch_no_push", 32'(n_pops), 32'd0);
    check("glitch_rx_valid", 32'(rx_valid), 32'd0);

    send(16'h0003, 1'b0, 1'b0, 17'h0_0003);
    send(16'h0001, 1'b1, 1'b0, 17'h0_0001);
    send(16'h0001, 1'b0, 1'b0, 17'h1_0001);
    send(16'h0001, 1'b0, 1'b1, 17'h0_0001);
    repeat (8) tick();
    parity_sel = 1'b0;

    // Good parity word with latency check.
    rxq.push_back(17'h0_0001);
    gpio_out = 17'h1_0001;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rx_latency_not_yet", 32'(rx_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rx_latency_valid", 32'(rx_valid), 32'd1);
    check("rx_latency_data", 32'(rx_data), 32'h0001);
    #1;
    repeat (3) tick();

    rxq.push_back(17'h1_0002);
    hold_rx(17'h0_0002, 5);
    check("perr_count_one", 32'(perr_count), 32'd1);

    pops_before = n_pops;
    rxq.push_back(17'h0_0004);
    hold_rx(17'h1_0004, 100);
    check("duplicate_single_push", 32'(n_pops - pops_before), 32'd1);

    // Overflow: five distinct words with the consumer stalled.
    rx_ready = 1'b0;
    ovf_words[0] = 17'h0_0011; ovf_words[1] = 17'h0_0022; ovf_words[2] = 17'h1_0033;
    ovf_words[3] = 17'h0_0044; ovf_words[4] = 17'h0_0055;
    rxq.push_back(17'h0_0011); rxq.push_back(17'h0_0022);
    rxq.push_back(17'h1_0033); rxq.push_back(17'h0_0044);
    for (int i = 0; i < 5; i++) hold_rx(ovf_words[i], 4);
    check("overflow_set", 32'(rx_overflow), 32'd1);
    check("perr_count_two", 32'(perr_count), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", 32'(rx_overflow), 32'd0);
    check("clr_perr_count", 32'(perr_count), 32'd0);
    check("clr_keeps_fifo", 32'(rx_valid), 32'd1);
    pops_before = n_pops;
    rx_ready = 1'b1;
    repeat (8) tick();
    check("overflow_drain_count", 32'(n_pops - pops_before), 32'd4);

    // Reset during TX hold with two RX entries queued.
    rx_ready = 1'b0;
    hold_rx(17'h0_0066, 4);
    hold_rx(17'h1_0077, 4);
    check("pre_reset_rx_valid", 32'(rx_valid), 32'd1);
    check("pre_reset_perr_count", 32'(perr_count), 32'd1);
    send(16'h00A5, 1'b0, 1'b0, 17'h0_00A5);
    tick();
    reset = 1'b1;
    gpio_out = '0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_gpio_in", 32'(gpio_in), 32'h0);
    check("midreset_tx_ready", 32'(tx_ready), 32'h1);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_rx_overflow", 32'(rx_overflow), 32'h0);
    check("midreset_perr_count", 32'(perr_count), 32'h0);
    #1;
    rx_ready = 1'b1;
    repeat (10) tick();
    check("tx_queue_drained", 32'(txq.size()), 32'd0);
    check("rx_queue_drained", 32'(rxq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
